rtc_bus_arbiter: RTL and testbench

- Sequences multiplexed address/data bus cycles (AD, CS, WR, RD, 8-bit bidirectional `salient`) to the external real-time-clock chip.
- Arbitrates bus access between two requesters:
  - port 0: PicoBlaze I/O port, read or write;
  - port 1: periodic time-refresh scanner, read only.
- Sits between the PicoBlaze port decoding and the top-level RTC pins; it is the only driver of those pins.

---
 rtl/rtc_bus_arbiter.sv | 222 ++++++++++++++++++++++
 tb/tb_rtc_bus_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_bus_arbiter.sv
// rtc_bus_arbiter
//   Sequences multiplexed address/data bus cycles to the external real-time
//   clock chip and arbitrates bus access between two requesters:
//     port 0 - PicoBlaze I/O port, read or write
//     port 1 - periodic time-refresh scanner, read only
//   This block is the only driver of the RTC pins.
//
// Ports
//   clk              system clock, all state on the rising edge
//   reset            asynchronous, active-low reset
//   req0/we0         port-0 request (level) and direction (1 = write)
//   addr0/wdata0     port-0 RTC register address and write data
//   req1/addr1       port-1 request (level, always a read) and address
//   gnt0/gnt1        grant, held from transaction start through DONE
//   done             one-cycle pulse at the end of a transaction
//   rdata            last read data, held until the next read completes
//   busy             high in every state except IDLE
//   AD/CS/WR/RD      RTC strobes, active-low, idle high
//   salient          RTC multiplexed bus, high-Z unless this block drives it
//
// Every output is registered. The combinational logic computes the next state
// and the output values for that next state, so strobes and bus drive change
// together on a clock edge.

module rtc_bus_arbiter #(
    parameter int PHASE_CYC = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic       we0,
    input  logic [7:0] addr0,
    input  logic [7:0] wdata0,
    input  logic       req1,
    input  logic [7:0] addr1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       done,
    output logic [7:0] rdata,
    output logic       busy,
    output logic       AD,
    output logic       CS,
    output logic       WR,
    output logic       RD,
    inout  wire  [7:0] salient
);

    localparam int            CW      = (PHASE_CYC > 1) ? $clog2(PHASE_CYC) : 1;
    localparam logic [CW-1:0] PH_LAST = CW'(PHASE_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADR_SET,
        S_ADR_STB,
        S_ADR_HLD,
        S_GAP,
        S_DAT_STB,
        S_DAT_HLD,
        S_DONE
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;

    // port_q is both the port currently served and, in IDLE, the last port
    // granted; it resets to 1 so port 0 wins the first tie.
    logic       port_q, port_nxt;
    logic       we_q, we_nxt;
    logic [7:0] addr_q, addr_nxt;
    logic [7:0] wdata_q, wdata_nxt;

    logic       drive_q, drive_nxt;
    logic [7:0] dout_q, dout_nxt;
    logic       ad_nxt, cs_nxt, wr_nxt, rd_nxt;
    logic       sample_rd;

    assign salient = drive_q ? dout_q : 8'bz;

    // Next state, phase counter and transaction latches.
    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path
        // leaves a value unassigned and no latch is inferred.
        state_nxt = state;
        cnt_nxt   = cnt;
        port_nxt  = port_q;
        we_nxt    = we_q;
        addr_nxt  = addr_q;
        wdata_nxt = wdata_q;

        case (state)
            S_IDLE: begin
                cnt_nxt = '0;
                // Round-robin: on a tie, port 0 goes only if port 1 went last.
                if (req0 && (!req1 || port_q)) begin
                    port_nxt  = 1'b0;
                    we_nxt    = we0;
                    addr_nxt  = addr0;
                    wdata_nxt = wdata0;
                    state_nxt = S_ADR_SET;
                end else if (req1) begin
                    port_nxt  = 1'b1;
                    we_nxt    = 1'b0;
                    addr_nxt  = addr1;
                    state_nxt = S_ADR_SET;
                end
            end
            S_DONE: begin
                cnt_nxt   = '0;
                state_nxt = S_IDLE;
            end
            default: begin
                if (cnt == PH_LAST) begin
                    cnt_nxt = '0;
                    case (state)
                        S_ADR_SET: state_nxt = S_ADR_STB;
                        S_ADR_STB: state_nxt = S_ADR_HLD;
                        S_ADR_HLD: state_nxt = S_GAP;
                        S_GAP:     state_nxt = S_DAT_STB;
                        S_DAT_STB: state_nxt = S_DAT_HLD;
                        S_DAT_HLD: state_nxt = S_DONE;
                        default:   state_nxt = S_IDLE;
                    endcase
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
        endcase
    end

    // Pin values for the state being entered. Address is shown only while AD
    // is low and the bus is driven, so AD never falls on a floating bus.
    always_comb begin
        ad_nxt    = 1'b1;
        cs_nxt    = 1'b1;
        wr_nxt    = 1'b1;
        rd_nxt    = 1'b1;
        drive_nxt = 1'b0;
        dout_nxt  = addr_nxt;

        case (state_nxt)
            S_ADR_SET: begin
                ad_nxt    = 1'b0;
                drive_nxt = 1'b1;
            end
            S_ADR_STB: begin
                ad_nxt    = 1'b0;
                cs_nxt    = 1'b0;
                wr_nxt    = 1'b0;
                drive_nxt = 1'b1;
            end
            S_ADR_HLD: begin
                ad_nxt    = 1'b0;
                drive_nxt = 1'b1;
            end
            S_DAT_STB: begin
                cs_nxt = 1'b0;
                if (we_nxt) begin
                    wr_nxt    = 1'b0;
                    drive_nxt = 1'b1;
                    dout_nxt  = wdata_nxt;
                end else begin
                    rd_nxt = 1'b0;
                end
            end
            S_DAT_HLD: begin
                // Write data stays on the bus past the WR rising edge.
                drive_nxt = we_nxt;
                dout_nxt  = wdata_nxt;
            end
            default: ;
        endcase
    end

    // The chip drives salient while RD is low; capture it on the final
    // DAT_STB cycle, just before RD is released.
    assign sample_rd = (state == S_DAT_STB) && (cnt == PH_LAST) && !we_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            port_q  <= 1'b1;
            we_q    <= 1'b0;
            addr_q  <= 8'h00;
            wdata_q <= 8'h00;
            drive_q <= 1'b0;
            dout_q  <= 8'h00;
            AD      <= 1'b1;
            CS      <= 1'b1;
            WR      <= 1'b1;
            RD      <= 1'b1;
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            done    <= 1'b0;
            busy    <= 1'b0;
            rdata   <= 8'h00;
        end else begin
            // NOTE: non-blocking assignments make every register load from
            // pre-edge values, independent of statement order.
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            port_q  <= port_nxt;
            we_q    <= we_nxt;
            addr_q  <= addr_nxt;
            wdata_q <= wdata_nxt;
            drive_q <= drive_nxt;
            dout_q  <= dout_nxt;
            AD      <= ad_nxt;
            CS      <= cs_nxt;
            WR      <= wr_nxt;
            RD      <= rd_nxt;
            gnt0    <= (state_nxt != S_IDLE) && !port_nxt;
            gnt1    <= (state_nxt != S_IDLE) && port_nxt;
            done    <= (state_nxt == S_DONE);
            busy    <= (state_nxt != S_IDLE);
            if (sample_rd) begin
                rdata <= salient;
            end
        end
    end

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// tb_rtc_bus_arbiter
//   Self-checking bench for rtc_bus_arbiter with PHASE_CYC = 2.
//   A transaction-level model predicts, from the offset of each cycle within
//   a transaction, what every output must be; a compare process checks the
//   DUT against it on every falling edge. Directed scenarios add literal
//   expectations (latency, strobe widths, grant order, read data).
//   The bus carries a pull-up, so a released bus reads 8'hFF.

module tb_rtc_bus_arbiter;

    localparam int P        = 2;
    localparam int TXN      = 6 * P;   // offset of the DONE cycle from the grant
    localparam logic [7:0] BUS_IDLE = 8'hFF;

    logic       clk    = 1'b0;
    logic       reset  = 1'b1;
    logic       req0   = 1'b0;
    logic       we0    = 1'b0;
    logic [7:0] addr0  = 8'h00;
    logic [7:0] wdata0 = 8'h00;
    logic       req1   = 1'b0;
    logic [7:0] addr1  = 8'h00;
    logic       gnt0, gnt1, done, busy, AD, CS, WR, RD;
    logic [7:0] rdata;
    tri1  [7:0] salient;

    // RTC chip stand-in: answers reads while RD is low.
    logic [7:0] rtc_val = 8'h00;
    assign salient = (RD == 1'b0) ? rtc_val : 8'bz;

    rtc_bus_arbiter #(.PHASE_CYC(P)) dut (
        .clk     (clk),
        .reset   (reset),
        .req0    (req0),
        .we0     (we0),
        .addr0   (addr0),
        .wdata0  (wdata0),
        .req1    (req1),
        .addr1   (addr1),
        .gnt0    (gnt0),
        .gnt1    (gnt1),
        .done    (done),
        .rdata   (rdata),
        .busy    (busy),
        .AD      (AD),
        .CS      (CS),
        .WR      (WR),
        .RD      (RD),
        .salient (salient)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit check_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    bit         m_busy;
    int         m_k;
    int         m_port;
    bit         m_we;
    logic [7:0] m_addr, m_wdata, m_rdata;
    int         m_last;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy  = 1'b0;
            m_k     = 0;
            m_port  = 0;
            m_we    = 1'b0;
            m_addr  = 8'h00;
            m_wdata = 8'h00;
            m_rdata = 8'h00;
            m_last  = 1;
        end else if (m_busy) begin
            if (m_k == 5 * P - 1 && !m_we) m_rdata = rtc_val;
            if (m_k == TXN) m_busy = 1'b0;
            else            m_k++;
        end else if (req0 || req1) begin
            if (req0 && (!req1 || m_last == 1)) begin
                m_port  = 0;
                m_we    = we0;
                m_addr  = addr0;
                m_wdata = wdata0;
            end else begin
                m_port  = 1;
                m_we    = 1'b0;
                m_addr  = addr1;
                m_wdata = 8'h00;
            end
            m_last = m_port;
            m_busy = 1'b1;
            m_k    = 0;
        end
    end

    // ---------------- compare process and monitors ----------------
    int n_ad = 0, n_cswr = 0, n_wrlow = 0, n_rd = 0, n_rdwr = 0, n_both = 0, n_watch = 0;
    logic [7:0] watch = 8'h00;
    int order[$];
    logic p_gnt0 = 1'b0, p_gnt1 = 1'b0;

    always @(negedge clk) begin
        int         ph;
        logic       e_ad, e_cs, e_wr, e_rd, e_dn;
        logic [7:0] e_bus;
        if (check_en) begin
            ph    = m_busy ? ((m_k == TXN) ? 6 : m_k / P) : -1;
            e_ad  = 1'b1; e_cs = 1'b1; e_wr = 1'b1; e_rd = 1'b1; e_dn = 1'b0;
            e_bus = BUS_IDLE;
            case (ph)
                0: begin e_ad = 1'b0; e_bus = m_addr; end
                1: begin e_ad = 1'b0; e_cs = 1'b0; e_wr = 1'b0; e_bus = m_addr; end
                2: begin e_ad = 1'b0; e_bus = m_addr; end
                4: begin
                    e_cs = 1'b0;
                    if (m_we) begin e_wr = 1'b0; e_bus = m_wdata; end
                    else      begin e_rd = 1'b0; e_bus = rtc_val; end
                end
                5: if (m_we) e_bus = m_wdata;
                6: e_dn = 1'b1;
                default: ;
            endcase
            check("outputs{gnt0,gnt1,done,busy,AD,CS,WR,RD}",
                  {gnt0, gnt1, done, busy, AD, CS, WR, RD},
                  {(m_busy && m_port == 0), (m_busy && m_port == 1), e_dn, m_busy,
                   e_ad, e_cs, e_wr, e_rd});
            check("salient", salient, e_bus);
            check("rdata", rdata, m_rdata);

            if (!AD) n_ad++;
            if (!CS && !WR) n_cswr++;
            if (!WR) n_wrlow++;
            if (!RD) n_rd++;
            if (!RD && !WR) n_rdwr++;
            if (gnt0 && gnt1) n_both++;
            if (salient === watch) n_watch++;
            if (gnt0 && !p_gnt0) order.push_back(0);
            if (gnt1 && !p_gnt1) order.push_back(1);
            p_gnt0 = gnt0;
            p_gnt1 = gnt1;
        end
    end

    // ---------------- stimulus helpers ----------------
    int b_ad, b_cswr, b_wrlow, b_rd, b_rdwr, b_watch;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic snap();
        b_ad = n_ad; b_cswr = n_cswr; b_wrlow = n_wrlow;
        b_rd = n_rd; b_rdwr = n_rdwr; b_watch = n_watch;
    endtask

    // Runs until done is seen; returns the cycle of the first grant seen and
    // the cycle of done. A missing done is a failed comparison.
    task automatic run_until_done(output int g_cyc, output int d_cyc);
        bit seen_g;
        bit fin;
        seen_g = 1'b0;
        fin    = 1'b0;
        g_cyc  = -1;
        d_cyc  = -1;
        for (int i = 0; i < 60 && !fin; i++) begin
            tick();
            if (!seen_g && (gnt0 || gnt1)) begin
                seen_g = 1'b1;
                g_cyc  = cyc;
            end
            if (done) begin
                d_cyc = cyc;
                fin   = 1'b1;
            end
        end
        if (!fin) begin
            n_tests++;
            n_fail++;
            $display("FAIL done_timeout: got no done, expected one within 60 cycles");
        end
    endtask

    // Bounded wait for the write data-strobe phase (AD high, CS and WR low).
    task automatic wait_dat_stb();
        bit fin;
        fin = 1'b0;
        for (int i = 0; i < 40 && !fin; i++) begin
            tick();
            if (AD && !CS && !WR) fin = 1'b1;
        end
        if (!fin) begin
            n_tests++;
            n_fail++;
            $display("FAIL dat_stb_timeout: got no DAT_STB, expected one within 40 cycles");
        end
    endtask

    task automatic wait_gnt0();
        bit fin;
        fin = 1'b0;
        for (int i = 0; i < 40 && !fin; i++) begin
            tick();
            if (gnt0) fin = 1'b1;
        end
        if (!fin) begin
            n_tests++;
            n_fail++;
            $display("FAIL gnt0_timeout: got no gnt0, expected one within 40 cycles");
        end
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int g, d, g2, d1, o_base;

        // Reset values.
        #1 reset = 1'b0;
        check_en = 1'b1;
        repeat (3) tick();
        check("rst_strobes", {AD, CS, WR, RD}, 4'hF);
        check("rst_salient", salient, BUS_IDLE);
        check("rst_rdata", rdata, 8'h00);
        check("rst_busy", busy, 1'b0);
        reset = 1'b1;
        repeat (20) tick();
        check("idle_busy", busy, 1'b0);

        // Port-0 write 0x45 to 0x21.
        snap();
        watch  = 8'h45;
        we0    = 1'b1;
        addr0  = 8'h21;
        wdata0 = 8'h45;
        req0   = 1'b1;
        run_until_done(g, d);
        req0 = 1'b0;
        check("wr_done_offset", d - g, 12);
        tick();
        check("wr_ad_low_cycles", n_ad - b_ad, 6);
        check("wr_cs_wr_low_cycles", n_cswr - b_cswr, 4);
        check("wr_data_cycles", n_watch - b_watch, 4);
        check("wr_rd_low_cycles", n_rd - b_rd, 0);
        check("wr_rdata_kept", rdata, 8'h00);

        // Port-1 read of 0x23; chip answers 0x59.
        snap();
        rtc_val = 8'h59;
        addr1   = 8'h23;
        req1    = 1'b1;
        run_until_done(g, d);
        check("rd_rdata_at_done", rdata, 8'h59);
        req1 = 1'b0;
        check("rd_done_offset", d - g, 12);
        tick();
        check("rd_rd_low_cycles", n_rd - b_rd, 2);
        check("rd_wr_low_cycles", n_wrlow - b_wrlow, 2);
        check("rd_rd_wr_overlap", n_rdwr - b_rdwr, 0);

        // Simultaneous requests after reset, both held.
        reset = 1'b0;
        tick();
        reset   = 1'b1;
        o_base  = order.size();
        rtc_val = 8'h3C;
        we0     = 1'b1;
        addr0   = 8'h10;
        wdata0  = 8'h99;
        addr1   = 8'h11;
        req0    = 1'b1;
        req1    = 1'b1;
        run_until_done(g, d1);
        run_until_done(g2, d);
        check("rr_idle_gap", g2 - d1, 2);
        run_until_done(g, d);
        req0 = 1'b0;
        req1 = 1'b0;
        tick();
        check("rr_grant_count", order.size() - o_base, 3);
        if (order.size() - o_base == 3) begin
            check("rr_first",  order[o_base],     0);
            check("rr_second", order[o_base + 1], 1);
            check("rr_third",  order[o_base + 2], 0);
        end
        check("rr_never_both", n_both, 0);
        check("rr_rdata", rdata, 8'h3C);

        // Reset mid-transaction during DAT_STB of a write.
        we0    = 1'b1;
        addr0  = 8'h40;
        wdata0 = 8'h81;
        req0   = 1'b1;
        wait_dat_stb();
        #1 reset = 1'b0;
        #1;
        check("async_rst_strobes", {AD, CS, WR, RD}, 4'hF);
        check("async_rst_salient", salient, BUS_IDLE);
        check("async_rst_busy", {busy, gnt0}, 2'b00);
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("restart_gnt0", gnt0, 1'b1);
        check("restart_ad", AD, 1'b0);
        check("restart_addr", salient, 8'h40);
        run_until_done(g, d);
        req0 = 1'b0;
        tick();

        // Port-0 inputs change the cycle after the grant.
        snap();
        watch  = 8'h7E;
        we0    = 1'b1;
        addr0  = 8'h30;
        wdata0 = 8'h7E;
        req0   = 1'b1;
        wait_gnt0();
        addr0  = 8'hAA;
        wdata0 = 8'hBB;
        tick();
        check("latched_addr", salient, 8'h30);
        run_until_done(g, d);
        req0 = 1'b0;
        tick();
        check("latched_wdata_cycles", n_watch - b_watch, 4);

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no end of test, expected it before 200000 time units");
        $fatal(1, "bench timeout");
    end

endmodule
